// File: rtl/display_scheduler.sv
// Round-robin scheduler that shows one of three requesters' 16-bit values on a
// 7-segment driver for a fixed hold time, followed by a blank gap.
module display_scheduler #(
    parameter int unsigned HOLD_CYCLES  = 50000000,
    parameter int unsigned BLANK_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req_valid,
    input  logic [15:0] req_data0,
    input  logic [15:0] req_data1,
    input  logic [15:0] req_data2,
    output logic [2:0]  req_ready,
    input  logic        pin,
    output logic [15:0] number,
    output logic        on,
    output logic [1:0]  src,
    output logic        busy
);

    localparam int unsigned CNT_W  = 26;
    localparam int unsigned DATA_W = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHOW  = 2'd1;
    localparam logic [1:0] S_BLANK = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic             HAS_BLANK  = (BLANK_CYCLES != 0);

    localparam logic [1:0] NO_SRC = 2'd3;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_number;
    logic              r_on;
    logic [1:0]        r_src;
    logic              r_busy;
    logic [1:0]        r_ptr;

    logic [1:0]        w_start;
    logic [1:0]        w_gidx;
    logic [2:0]        w_grant;
    logic              w_xfer;
    logic [DATA_W-1:0] w_data;

    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_number_nxt;
    logic [1:0]        w_src_nxt;
    logic [1:0]        w_ptr_nxt;

    // First valid requester in the order a, b, c; 3 when none is valid.
    function automatic logic [1:0] f_pick(
        input logic [2:0] v,
        input logic [1:0] a,
        input logic [1:0] b,
        input logic [1:0] c
    );
        logic [1:0] idx;
        idx = NO_SRC;
        if (v[c]) idx = c;
        if (v[b]) idx = b;
        if (v[a]) idx = a;
        return idx;
    endfunction

    // Round-robin arbitration, search begins one past the last grant.
    always_comb begin
        w_start = 2'd0;
        w_gidx  = NO_SRC;
        w_grant = 3'b000;

        if (r_ptr == 2'd0) begin
            w_start = 2'd1;
        end else if (r_ptr == 2'd1) begin
            w_start = 2'd2;
        end

        case (w_start)
            2'd1:    w_gidx = f_pick(req_valid, 2'd1, 2'd2, 2'd0);
            2'd2:    w_gidx = f_pick(req_valid, 2'd2, 2'd0, 2'd1);
            default: w_gidx = f_pick(req_valid, 2'd0, 2'd1, 2'd2);
        endcase

        if (reset && (r_state == S_IDLE)) begin
            case (w_gidx)
                2'd0:    w_grant = 3'b001;
                2'd1:    w_grant = 3'b010;
                2'd2:    w_grant = 3'b100;
                default: w_grant = 3'b000;
            endcase
        end
    end

    assign req_ready = w_grant;
    assign w_xfer    = |w_grant;

    always_comb begin
        case (w_gidx)
            2'd1:    w_data = req_data1;
            2'd2:    w_data = req_data2;
            default: w_data = req_data0;
        endcase
    end

    // Next-state and datapath updates; every register holds by default.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_number_nxt = r_number;
        w_src_nxt    = r_src;
        w_ptr_nxt    = r_ptr;

        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt  = S_SHOW;
                    w_cnt_nxt    = HOLD_LOAD;
                    w_number_nxt = w_data;
                    w_src_nxt    = w_gidx;
                    w_ptr_nxt    = w_gidx;
                end
            end

            S_SHOW: begin
                if (!pin) begin
                    if (r_cnt == '0) begin
                        if (HAS_BLANK) begin
                            w_state_nxt = S_BLANK;
                            w_cnt_nxt   = BLANK_LOAD;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
            end

            S_BLANK: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // on/busy are registered from the next state so they track it exactly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_number <= '0;
            r_on     <= 1'b0;
            r_src    <= NO_SRC;
            r_busy   <= 1'b0;
            r_ptr    <= 2'd2;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_number <= w_number_nxt;
            r_on     <= (w_state_nxt == S_SHOW);
            r_src    <= w_src_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_ptr    <= w_ptr_nxt;
        end
    end

    assign number = r_number;
    assign on     = r_on;
    assign src    = r_src;
    assign busy   = r_busy;

endmodule
